median_frame_sequencer: RTL and testbench
=========================================

Name: median_frame_sequencer

Overview:
Streaming controller that drives the median filter core row by row. It accepts packed pixels on a valid/ready input stream and assembles each full row. It maintains the 3-row window on the core's row_in, pulses en_in, and tracks buffer_counter. Once each filtered row is ready, it serializes the row back out on a valid/ready output stream. It sits between the system DMA/stream fabric and the median core, replacing CSR-driven row loading for whole-frame operation.

Parameters:
ROW, 256, pixels per row
COL, 256, rows per frame (min 3)
WIDTH, 8, bits per pixel
CORE_LAT, 1, cycles from en_in pulse to valid core_row_out (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  1-cycle pulse; begins a frame when idle
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse after last word of frame accepted downstream
in_valid  in  1  input word valid
in_ready  out  1  sequencer accepts input word
in_data  in  32  4 pixels; bits[8k+7:8k] = pixel 4n+k
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts
out_data  out  32  4 filtered pixels, same packing
out_last  out  1  high on last word of each output row
core_row_in  out  ROW*WIDTH*3  window; slot0 (low) oldest, slot2 newest
core_en  out  1  1-cycle load pulse to core
core_buffer_counter  out  9  rows loaded this frame (0..COL)
core_row_out  in  ROW*WIDTH  filtered middle row from core

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0, including core_row_in, staging row, and word index. State is IDLE. Reset mid-frame aborts with no done pulse.
- Transfer rule: a transfer occurs on valid && ready. out_data and out_last are held stable while out_valid && !out_ready.
- Constant: WPR = ROW/4 words per row; ROW must be a multiple of 4.
- IDLE: in_ready=0, busy=0. start -> FILL, busy=1, counter=0. start while busy is ignored.
- FILL: in_ready=1. Each accepted word writes staging[word_idx]. After word WPR-1 is accepted -> SHIFT (next cycle). At most one word per cycle.
- SHIFT (1 cycle): slot0<=slot1, slot1<=slot2, slot2<=staging; core_en=1; counter+=1.
  - If the new counter <3 -> FILL.
  - Otherwise -> WAIT.
- WAIT: CORE_LAT cycles. On its final cycle, capture core_row_out into the output row register -> DRAIN.
- DRAIN: out_valid=1. Emit WPR words in order, word 0 first. out_last is set on word WPR-1. After the last accepted word:
  - If counter==COL -> DONE.
  - Otherwise -> FILL.
- DONE (1 cycle): done=1, busy=0, counter<=0 -> IDLE.
- Frame output is COL-2 rows; no border rows are emitted.
- Input is never accepted outside FILL, including during DRAIN back-pressure; there is no input/output overlap.
- core_buffer_counter saturates at COL and never wraps within a frame.

Optional Feature:
MEDIAN_SEQ_PERF_EN
- Defined: adds output stall_cycles [31:0]. It counts cycles in FILL with !in_valid plus cycles in DRAIN with !out_ready. It clears on accepted start, holds after done, and resets to 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Package median_pkg holds:
  - ROW/COL/WIDTH defaults
  - PIX_PER_WORD=4
  - WPR
  - the state enum {IDLE, FILL, SHIFT, WAIT, DRAIN, DONE}
  - word-index width $clog2(WPR)
- Sub-module median_row_serializer owns the output row register, word index, out_valid/out_last, and the handshake. It has a load/done interface to the FSM.

Test Plan:
1. ROW=8, COL=4, CORE_LAT=1. Stream rows of constant values 10,20,30,40 with out_ready=1.
   -> core_en pulses 4x; core_buffer_counter steps 1..4.
   -> 2 output rows of 2 words each, out_last on words 2 and 4.
   -> done pulses once; busy falls with done.
2. Window check: after the 3rd SHIFT, core_row_in slot0=0x0A.., slot1=0x14.., slot2=0x1E.. (all pixels).
   -> After the 4th SHIFT, slot0=0x14, slot2=0x28.
3. Drive out_ready=0 for 5 cycles mid-row.
   -> out_data/out_last stable, in_ready=0 throughout, no words lost.
   -> With MEDIAN_SEQ_PERF_EN, stall_cycles increments by 5.
4. Randomly gap in_valid, e.g. one 3-cycle gap.
   -> Words still packed in order: pixel 4n+k taken from in_data[8k+7:8k].
5. Assert rst_n=0 during DRAIN of row 1.
   -> All outputs 0 immediately, no done.
   -> A new start then runs a full frame correctly from counter 0.
6. Pulse start while busy.
   -> Ignored; frame completes with exactly COL-2 output rows and one done.

Source files
------------

// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants, state encoding and helpers for the median frame sequencer
package median_pkg;

  localparam int ROW_DEF      = 256;
  localparam int COL_DEF      = 256;
  localparam int WIDTH_DEF    = 8;
  localparam int CORE_LAT_DEF = 1;

  localparam int PIX_PER_WORD = 4;
  localparam int DATA_W       = 32;
  localparam int WPR          = ROW_DEF / PIX_PER_WORD;
  localparam int WORD_IDX_W   = $clog2(WPR);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHIFT,
    WAIT,
    DRAIN,
    DONE
  } state_e;

  // Index width that stays legal (>=1 bit) even for a single-entry range
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/median_frame_sequencer_if.sv
// rtl/median_frame_sequencer_if.sv - pixel input and filtered output stream bundle
interface median_frame_sequencer_if;
  import median_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Sequencer side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Fabric side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/median_row_serializer.sv
// rtl/median_row_serializer.sv - holds one filtered row and emits it word by word on a valid/ready stream
module median_row_serializer
  import median_pkg::*;
#(
  parameter int WPR_P = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_i,
  input  logic [WPR_P-1:0][DATA_W-1:0] row_i,
  output logic                         row_done_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_W-1:0]            out_data_o,
  output logic                         out_last_o
);

  localparam int IW = idx_width(WPR_P);
  localparam logic [IW-1:0] LAST_IDX = IW'(WPR_P - 1);

  logic [WPR_P-1:0][DATA_W-1:0] row_q;
  logic [IW-1:0]                idx_q;
  logic [IW-1:0]                idx_d;
  logic                         valid_q;
  logic                         last_q;
  logic                         xfer;

  assign xfer  = valid_q && out_ready_i;
  assign idx_d = idx_q + 1'b1;

  // Row capture on load, then advance one word per accepted transfer; data held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      row_q   <= row_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
      last_q  <= (WPR_P == 1);
    end else if (xfer) begin
      if (last_q) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        idx_q  <= idx_d;
        last_q <= (idx_d == LAST_IDX);
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign out_data_o  = row_q[idx_q];
  assign row_done_o  = xfer && last_q;

endmodule

// File: rtl/median_frame_sequencer.sv
// rtl/median_frame_sequencer.sv - frame-level row loader and output drainer for the median core (optional MEDIAN_SEQ_PERF_EN stall counter)
module median_frame_sequencer
  import median_pkg::*;
#(
  parameter int ROW      = ROW_DEF,
  parameter int COL      = COL_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  median_frame_sequencer_if.slave   strm,
  output logic [ROW*WIDTH*3-1:0]    core_row_in,
  output logic                      core_en,
  output logic [8:0]                core_buffer_counter,
  input  logic [ROW*WIDTH-1:0]      core_row_out
`ifdef MEDIAN_SEQ_PERF_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  // Pixels are packed four per 32-bit word, so WIDTH is expected to be 8
  localparam int WPR_L = ROW / PIX_PER_WORD;
  localparam int IW    = idx_width(WPR_L);
  localparam int LAT_W = idx_width(CORE_LAT);
  localparam logic [IW-1:0]    LAST_IDX = IW'(WPR_L - 1);
  localparam logic [8:0]       COL_CNT  = 9'(COL);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(CORE_LAT - 1);

  state_e                             state_q;
  logic                               busy_q;
  logic                               done_q;
  logic                               in_ready_q;
  logic                               core_en_q;
  logic [8:0]                         counter_q;
  logic [IW-1:0]                      word_idx_q;
  logic [LAT_W-1:0]                   lat_q;
  logic [WPR_L-1:0][DATA_W-1:0]       staging_q;
  logic [WPR_L-1:0][DATA_W-1:0]       row_d;
  logic [2:0][WPR_L*DATA_W-1:0]       window_q;
  logic                               in_xfer;
  logic                               load;
  logic                               row_done;

  assign in_xfer = in_ready_q && strm.in_valid;
  assign load    = (state_q == WAIT) && (lat_q == '0);

  // Completed row as it will look once the final word lands, so the window can shift on that same edge
  always_comb begin
    row_d           = staging_q;
    row_d[LAST_IDX] = strm.in_data;
  end

  // Frame sequencing: gather a row, push it into the window, wait on the core, drain the filtered row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      core_en_q  <= 1'b0;
      counter_q  <= '0;
      word_idx_q <= '0;
      lat_q      <= '0;
      staging_q  <= '0;
      window_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      core_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FILL;
            busy_q     <= 1'b1;
            counter_q  <= '0;
            word_idx_q <= '0;
            in_ready_q <= 1'b1;
          end
        end
        FILL: begin
          if (in_xfer) begin
            staging_q[word_idx_q] <= strm.in_data;
            if (word_idx_q == LAST_IDX) begin
              word_idx_q <= '0;
              in_ready_q <= 1'b0;
              window_q   <= {row_d, window_q[2], window_q[1]};
              core_en_q  <= 1'b1;
              counter_q  <= (counter_q == COL_CNT) ? counter_q : counter_q + 9'd1;
              state_q    <= SHIFT;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        SHIFT: begin
          if (counter_q < 9'd3) begin
            state_q    <= FILL;
            in_ready_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            lat_q   <= LAT_INIT;
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            state_q <= DRAIN;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        DRAIN: begin
          if (row_done) begin
            if (counter_q == COL_CNT) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          counter_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  median_row_serializer #(
    .WPR_P(WPR_L)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .row_i      (core_row_out),
    .row_done_o (row_done),
    .out_valid_o(strm.out_valid),
    .out_ready_i(strm.out_ready),
    .out_data_o (strm.out_data),
    .out_last_o (strm.out_last)
  );

  assign strm.in_ready       = in_ready_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign core_en             = core_en_q;
  assign core_buffer_counter = counter_q;
  assign core_row_in         = window_q;

`ifdef MEDIAN_SEQ_PERF_EN
  logic [31:0] stall_q;

  // Count cycles lost to an idle source while filling or a blocked sink while draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
    end else if ((state_q == FILL && !strm.in_valid) || (state_q == DRAIN && !strm.out_ready)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_median_frame_sequencer.sv
// tb/tb_median_frame_sequencer.sv - randomized self-checking bench for median_frame_sequencer
module tb_median_frame_sequencer;

  localparam int ROW      = 8;
  localparam int COL      = 4;
  localparam int WIDTH    = 8;
  localparam int CORE_LAT = 1;
  localparam int WPR      = ROW / 4;
  localparam int RW       = ROW * WIDTH;
  localparam int BOUND    = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [3*RW-1:0]   core_row_in;
  logic              core_en;
  logic [8:0]        core_buffer_counter;
  logic [RW-1:0]     core_row_out = '0;
`ifdef MEDIAN_SEQ_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  median_frame_sequencer_if sif();

  median_frame_sequencer #(
    .ROW(ROW), .COL(COL), .WIDTH(WIDTH), .CORE_LAT(CORE_LAT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .strm               (sif),
    .core_row_in        (core_row_in),
    .core_en            (core_en),
    .core_buffer_counter(core_buffer_counter),
    .core_row_out       (core_row_out)
`ifdef MEDIAN_SEQ_PERF_EN
    ,
    .stall_cycles       (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]      rows_m [COL][ROW];
  logic [8:0]      en_cnt_q [$];
  logic [3*RW-1:0] win_q [$];
  logic [31:0]     out_q [$];
  logic            last_q [$];
  logic            done_busy_q [$];
  int              done_cnt = 0;

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v [3];
    logic [7:0] t;
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[1];
  endfunction

  // Stand-in core: median of the three window slots, valid one cycle after core_en
  always @(posedge clk) begin
    if (core_en)
      for (int p = 0; p < ROW; p++)
        core_row_out[p*8 +: 8] <= med3(core_row_in[p*8 +: 8], core_row_in[RW + p*8 +: 8], core_row_in[2*RW + p*8 +: 8]);
  end

  // Observer: records core loads, accepted output words and done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_en) begin
        en_cnt_q.push_back(core_buffer_counter);
        win_q.push_back(core_row_in);
      end
      if (sif.out_valid && sif.out_ready) begin
        out_q.push_back(sif.out_data);
        last_q.push_back(sif.out_last);
      end
      if (done) begin
        done_cnt++;
        done_busy_q.push_back(busy);
      end
    end
  end

  function automatic logic [31:0] in_word(input int r, input int n);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rows_m[r][4*n + k];
    return w;
  endfunction

  function automatic logic [RW-1:0] row_vec(input int r);
    logic [RW-1:0] v;
    for (int p = 0; p < ROW; p++) v[8*p +: 8] = rows_m[r][p];
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input int r, input int n);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = med3(rows_m[r][4*n+k], rows_m[r+1][4*n+k], rows_m[r+2][4*n+k]);
    return w;
  endfunction

  task automatic gen_rows(input int mode);
    for (int r = 0; r < COL; r++)
      for (int p = 0; p < ROW; p++)
        rows_m[r][p] = (mode == 0) ? 8'(10 * (r + 1)) : 8'($urandom_range(0, 255));
  endtask

  task automatic clear_mon();
    en_cnt_q.delete(); win_q.delete(); out_q.delete(); last_q.delete(); done_busy_q.delete();
    done_cnt = 0;
  endtask

  task automatic feed_rows(input int nrows, input int gaps);
    bit acc;
    for (int r = 0; r < nrows; r++) begin
      for (int n = 0; n < WPR; n++) begin
        if (gaps != 0 && ((r == 1 && n == 0) || $urandom_range(0, 3) == 0)) begin
          sif.in_valid = 1'b0;
          repeat ((r == 1 && n == 0) ? 3 : $urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        sif.in_valid = 1'b1;
        sif.in_data  = in_word(r, n);
        acc = 1'b0;
        for (int t = 0; t < BOUND && !acc; t++) begin
          @(negedge clk);
          if (sif.in_ready) acc = 1'b1;
          @(posedge clk); #1;
        end
        if (!acc) begin
          n_cmp++; n_bad++;
          $display("FAIL in_accept_timeout: row %0d word %0d not accepted, required acceptance", r, n);
          sif.in_valid = 1'b0;
          return;
        end
      end
    end
    sif.in_valid = 1'b0;
  endtask

  task automatic drain(input int stall_mode);
    logic [31:0] d0;
    logic        l0;
    int t;
    sif.out_ready = 1'b1;
    if (stall_mode == 1) begin
      t = 0;
      while (out_q.size() < 1 && t < BOUND) begin @(posedge clk); #1; t++; end
      sif.out_ready = 1'b0;
      d0 = sif.out_data;
      l0 = sif.out_last;
      repeat (5) begin
        @(negedge clk);
        n_cmp++; if (sif.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b required 1", sif.out_valid); end
        n_cmp++; if (sif.out_data !== d0) begin n_bad++; $display("FAIL stall_data: got %h required %h", sif.out_data, d0); end
        n_cmp++; if (sif.out_last !== l0) begin n_bad++; $display("FAIL stall_last: got %b required %b", sif.out_last, l0); end
        n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b required 0", sif.in_ready); end
      end
      @(posedge clk); #1;
      sif.out_ready = 1'b1;
    end
    t = 0;
    while (done_cnt == 0 && t < BOUND) begin
      if (stall_mode == 2) sif.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; t++;
    end
    sif.out_ready = 1'b1;
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done not seen within %0d cycles, required one pulse", BOUND);
    end
  endtask

  task automatic spam_start();
    repeat (2) begin
      repeat (4) @(posedge clk);
      #1;
      if (busy) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string tag);
    logic [3*RW-1:0] w;
    int nw;
    n_cmp++; if (en_cnt_q.size() != COL) begin n_bad++; $display("FAIL %s en_pulses: got %0d required %0d", tag, en_cnt_q.size(), COL); end
    for (int k = 0; k < en_cnt_q.size() && k < COL; k++) begin
      n_cmp++; if (en_cnt_q[k] !== 9'(k + 1)) begin n_bad++; $display("FAIL %s counter_at_load%0d: got %0d required %0d", tag, k, en_cnt_q[k], k + 1); end
      if (k >= 2) begin
        w = win_q[k];
        for (int s = 0; s < 3; s++) begin
          n_cmp++;
          if (w[s*RW +: RW] !== row_vec(k - 2 + s)) begin
            n_bad++; $display("FAIL %s window_load%0d_slot%0d: got %h required %h", tag, k, s, w[s*RW +: RW], row_vec(k - 2 + s));
          end
        end
      end
    end
    nw = WPR * (COL - 2);
    n_cmp++; if (out_q.size() != nw) begin n_bad++; $display("FAIL %s out_words: got %0d required %0d", tag, out_q.size(), nw); end
    for (int i = 0; i < out_q.size() && i < nw; i++) begin
      n_cmp++; if (out_q[i] !== exp_word(i / WPR, i % WPR)) begin n_bad++; $display("FAIL %s out_data%0d: got %h required %h", tag, i, out_q[i], exp_word(i / WPR, i % WPR)); end
      n_cmp++; if (last_q[i] !== ((i % WPR) == WPR - 1)) begin n_bad++; $display("FAIL %s out_last%0d: got %b required %b", tag, i, last_q[i], (i % WPR) == WPR - 1); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s done_pulses: got %0d required 1", tag, done_cnt); end
    foreach (done_busy_q[i]) begin
      n_cmp++; if (done_busy_q[i] !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done: got %b required 0", tag, done_busy_q[i]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_after: got %b required 0", tag, busy); end
  endtask

  task automatic run_frame(input string tag, input int rowmode, input int gaps, input int stall_mode, input int spam);
    gen_rows(rowmode);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_on_start: got %b required 1", tag, busy); end
    fork
      feed_rows(COL, gaps);
      drain(stall_mode);
      if (spam != 0) spam_start();
    join
    repeat (4) @(posedge clk);
    #1;
    check_frame(tag);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b%b required 00", busy, done); end
    n_cmp++; if (sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b required 0", sif.in_ready); end
    n_cmp++; if (sif.out_valid !== 1'b0 || sif.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_ctl: got %b%b required 00", sif.out_valid, sif.out_last); end
    n_cmp++; if (sif.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h required 0", sif.out_data); end
    n_cmp++; if (core_en !== 1'b0 || core_buffer_counter !== 9'd0) begin n_bad++; $display("FAIL reset_core_ctl: got %b/%0d required 0/0", core_en, core_buffer_counter); end
    n_cmp++; if (core_row_in !== '0) begin n_bad++; $display("FAIL reset_window: got %h required 0", core_row_in); end
  endtask

  task automatic test_basic_frame();
    run_frame("basic", 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    run_frame("stall", 1, 0, 1, 0);
`ifdef MEDIAN_SEQ_PERF_EN
    n_cmp++; if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL stall_cycles: got %0d required 5", stall_cycles); end
`endif
  endtask

  task automatic test_input_gaps();
    run_frame("gaps", 1, 1, 2, 0);
  endtask

  task automatic test_reset_mid_drain();
    int t;
    gen_rows(1);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sif.out_ready = 1'b0;
    feed_rows(3, 0);
    t = 0;
    while (!sif.out_valid && t < BOUND) begin @(posedge clk); #1; t++; end
    n_cmp++; if (sif.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_reach_drain: got %b required 1", sif.out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || sif.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctl: got busy %b done %b in_ready %b required 000", busy, done, sif.in_ready); end
    n_cmp++; if (sif.out_valid !== 1'b0 || sif.out_data !== 32'h0 || sif.out_last !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out: got %b %h %b required 0 0 0", sif.out_valid, sif.out_data, sif.out_last); end
    n_cmp++; if (core_buffer_counter !== 9'd0 || core_row_in !== '0 || core_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_core: got counter %0d required 0 with zero window", core_buffer_counter); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sif.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_done: got done %0d busy %b required 0 0", done_cnt, busy); end
    run_frame("after_reset", 1, 0, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_frame("start_busy", 1, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_a", 1, 1, 2, 0);
    run_frame("b2b_b", 0, 0, 2, 0);
  endtask

  initial begin
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic_frame();
    test_stall();
    test_input_gaps();
    test_reset_mid_drain();
    test_start_while_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
